// File: rtl/td4_pkg.sv
// td4_pkg: shared definitions for the TD4 execution core.
//   - nibble_t      : 4-bit datapath word
//   - OP_*          : instruction opcodes (upper instruction nibble)
//   - state_e       : core sequencing FSM states
//   - alu_src_e     : operand select for the adder
//   - next_seq_pc() : sequential program counter advance (wraps 15 -> 0)
package td4_pkg;

    typedef logic [3:0] nibble_t;

    localparam nibble_t OP_ADD_A    = 4'b0000;
    localparam nibble_t OP_MOV_A_B  = 4'b0001;
    localparam nibble_t OP_IN_A     = 4'b0010;
    localparam nibble_t OP_MOV_A_IM = 4'b0011;
    localparam nibble_t OP_MOV_B_A  = 4'b0100;
    localparam nibble_t OP_ADD_B    = 4'b0101;
    localparam nibble_t OP_IN_B     = 4'b0110;
    localparam nibble_t OP_MOV_B_IM = 4'b0111;
    localparam nibble_t OP_OUT_B    = 4'b1001;
    localparam nibble_t OP_OUT_IM   = 4'b1011;
    localparam nibble_t OP_JNC      = 4'b1110;
    localparam nibble_t OP_JMP      = 4'b1111;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC  = 2'b01,
        ST_WAIT  = 2'b10,
        ST_HALT  = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        SRC_ZERO = 2'b00,
        SRC_A    = 2'b01,
        SRC_B    = 2'b10,
        SRC_IN   = 2'b11
    } alu_src_e;

    // 4-bit address space: the increment wraps naturally from 15 to 0.
    function automatic nibble_t next_seq_pc(input nibble_t pc);
        return pc + 4'd1;
    endfunction

endpackage

// File: rtl/td4_alu.sv
// td4_alu: combinational operand mux and 4-bit adder for the TD4 core.
// Ports:
//   src_sel  in  operand select (zero, A, B, in_port)
//   reg_a    in  register A
//   reg_b    in  register B
//   in_port  in  external input switches
//   imm      in  immediate addend
//   sum      out 4-bit sum, wraps mod 16
//   carry    out bit 4 of the 5-bit sum
module td4_alu
    import td4_pkg::*;
(
    input  alu_src_e   src_sel,
    input  logic [3:0] reg_a,
    input  logic [3:0] reg_b,
    input  logic [3:0] in_port,
    input  logic [3:0] imm,
    output logic [3:0] sum,
    output logic       carry
);

    nibble_t    operand_s;
    logic [4:0] sum_wide_s;

    // Select the adder operand; moves and loads use a zero operand or a zero addend.
    always_comb begin
        operand_s = 4'd0;
        case (src_sel)
            SRC_ZERO: operand_s = 4'd0;
            SRC_A:    operand_s = reg_a;
            SRC_B:    operand_s = reg_b;
            SRC_IN:   operand_s = in_port;
            default:  operand_s = 4'd0;
        endcase
    end

    assign sum_wide_s = {1'b0, operand_s} + {1'b0, imm};
    assign sum        = sum_wide_s[3:0];
    assign carry      = sum_wide_s[4];

endmodule

// File: rtl/td4_core.sv
// td4_core: TD4 execution core. Fetches one instruction per instruction
// period from program memory at pc_out, decodes it and commits the result
// to A, B, the output latch, the carry flag and the PC.
//
// Sequencing: FETCH (latch IR) -> EXEC (commit) -> WAIT (CYCLE_DIV-2 clocks,
// skipped when CYCLE_DIV == 2) -> FETCH. run=0 freezes everything.
//
// Parameters:
//   CYCLE_DIV   clocks per instruction period, 2..65535
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   run         execution enable
//   opcode      instruction upper nibble read at pc_out
//   immediate   instruction lower nibble read at pc_out
//   in_port     input switches, sampled at the EXEC edge
//   pc_out      program counter / memory address
//   reg_a       register A
//   reg_b       register B
//   out_port    output latch
//   carry       carry flag
//   retire      one-cycle pulse per committed instruction
//   halted      self-loop halt detected
//
// Build option: define TD4_HALT_EN to stop the core on a JMP to its own
// address (HALT state, halted=1 until rst). Without it halted is tied 0.
module td4_core
    import td4_pkg::*;
#(
    parameter int unsigned CYCLE_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [3:0] opcode,
    input  logic [3:0] immediate,
    input  logic [3:0] in_port,
    output logic [3:0] pc_out,
    output logic [3:0] reg_a,
    output logic [3:0] reg_b,
    output logic [3:0] out_port,
    output logic       carry,
    output logic       retire,
    output logic       halted
);

    // A WAIT phase only exists when the period is longer than FETCH+EXEC.
    localparam bit          HAS_WAIT  = (CYCLE_DIV > 2);
    localparam logic [15:0] WAIT_LAST = (CYCLE_DIV > 2) ? 16'(CYCLE_DIV - 3) : 16'd0;

    state_e      state_r;
    state_e      state_next_s;
    logic [7:0]  ir_r;
    logic [15:0] wait_cnt_r;
    nibble_t     pc_r;
    nibble_t     reg_a_r;
    nibble_t     reg_b_r;
    nibble_t     out_r;
    logic        carry_r;
    logic        retire_r;

    nibble_t     ir_op_s;
    nibble_t     ir_imm_s;
    logic        fetch_s;
    logic        commit_s;
    logic        wait_step_s;
    logic        wait_done_s;
    logic        halt_hit_s;

    alu_src_e    alu_src_s;
    nibble_t     alu_imm_s;
    nibble_t     alu_sum_s;
    logic        alu_carry_s;
    logic        wr_a_s;
    logic        wr_b_s;
    logic        wr_out_s;
    logic        use_alu_carry_s;
    nibble_t     out_val_s;
    nibble_t     pc_next_s;
    logic        carry_next_s;

    assign ir_op_s     = ir_r[7:4];
    assign ir_imm_s    = ir_r[3:0];
    assign wait_done_s = (wait_cnt_r == WAIT_LAST);

`ifdef TD4_HALT_EN
    // The PC still holds the JMP's own address during EXEC.
    assign halt_hit_s = (ir_op_s == OP_JMP) && (ir_imm_s == pc_r);
`else
    assign halt_hit_s = 1'b0;
`endif

    td4_alu u_alu (
        .src_sel (alu_src_s),
        .reg_a   (reg_a_r),
        .reg_b   (reg_b_r),
        .in_port (in_port),
        .imm     (alu_imm_s),
        .sum     (alu_sum_s),
        .carry   (alu_carry_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; run=0 holds every state except HALT.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_FETCH: begin
                if (run) begin
                    state_next_s = ST_EXEC;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if (!run) begin
                    state_next_s = ST_EXEC;
                end else if (halt_hit_s) begin
                    state_next_s = ST_HALT;
                end else if (HAS_WAIT) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_WAIT: begin
                if (run && wait_done_s) begin
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_HALT: begin
`ifdef TD4_HALT_EN
                state_next_s = ST_HALT;
`else
                state_next_s = ST_FETCH;
`endif
            end
            default: state_next_s = ST_FETCH;
        endcase
    end

    // FSM outputs: per-state strobes gated by run.
    always_comb begin
        fetch_s     = 1'b0;
        commit_s    = 1'b0;
        wait_step_s = 1'b0;
        case (state_r)
            ST_FETCH: fetch_s     = run;
            ST_EXEC:  commit_s    = run;
            ST_WAIT:  wait_step_s = run;
            ST_HALT:  fetch_s     = 1'b0;
            default:  fetch_s     = 1'b0;
        endcase
    end

    // Instruction decode; anything unlisted is a NOP (pc+1, carry cleared).
    always_comb begin
        alu_src_s       = SRC_ZERO;
        alu_imm_s       = ir_imm_s;
        wr_a_s          = 1'b0;
        wr_b_s          = 1'b0;
        wr_out_s        = 1'b0;
        use_alu_carry_s = 1'b0;
        out_val_s       = reg_b_r;
        pc_next_s       = next_seq_pc(pc_r);
        case (ir_op_s)
            OP_ADD_A: begin
                alu_src_s       = SRC_A;
                wr_a_s          = 1'b1;
                use_alu_carry_s = 1'b1;
            end
            OP_ADD_B: begin
                alu_src_s       = SRC_B;
                wr_b_s          = 1'b1;
                use_alu_carry_s = 1'b1;
            end
            OP_MOV_A_IM: wr_a_s = 1'b1;
            OP_MOV_B_IM: wr_b_s = 1'b1;
            // Register moves and input loads pass the operand through unchanged.
            OP_MOV_A_B: begin
                alu_src_s = SRC_B;
                alu_imm_s = 4'd0;
                wr_a_s    = 1'b1;
            end
            OP_MOV_B_A: begin
                alu_src_s = SRC_A;
                alu_imm_s = 4'd0;
                wr_b_s    = 1'b1;
            end
            OP_IN_A: begin
                alu_src_s = SRC_IN;
                alu_imm_s = 4'd0;
                wr_a_s    = 1'b1;
            end
            OP_IN_B: begin
                alu_src_s = SRC_IN;
                alu_imm_s = 4'd0;
                wr_b_s    = 1'b1;
            end
            OP_OUT_B: begin
                wr_out_s  = 1'b1;
                out_val_s = reg_b_r;
            end
            OP_OUT_IM: begin
                wr_out_s  = 1'b1;
                out_val_s = ir_imm_s;
            end
            OP_JMP: pc_next_s = ir_imm_s;
            // JNC looks at the carry left by the previous instruction.
            OP_JNC: begin
                if (!carry_r) begin
                    pc_next_s = ir_imm_s;
                end else begin
                    pc_next_s = next_seq_pc(pc_r);
                end
            end
            default: pc_next_s = next_seq_pc(pc_r);
        endcase
    end

    assign carry_next_s = use_alu_carry_s & alu_carry_s;

    // Instruction register: captured at the end of the FETCH cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_r <= 8'd0;
        end else if (fetch_s) begin
            ir_r <= {opcode, immediate};
        end
    end

    // Architectural state: every field updates together at the EXEC edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r    <= 4'd0;
            reg_a_r <= 4'd0;
            reg_b_r <= 4'd0;
            out_r   <= 4'd0;
            carry_r <= 1'b0;
        end else if (commit_s) begin
            pc_r    <= pc_next_s;
            carry_r <= carry_next_s;
            if (wr_a_s) begin
                reg_a_r <= alu_sum_s;
            end
            if (wr_b_s) begin
                reg_b_r <= alu_sum_s;
            end
            if (wr_out_s) begin
                out_r <= out_val_s;
            end
        end
    end

    // Retire pulse: high for the one cycle after each commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_r <= 1'b0;
        end else begin
            retire_r <= commit_s;
        end
    end

    // Divider counter: counts WAIT cycles and rearms to zero on exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r <= 16'd0;
        end else if (wait_step_s) begin
            if (wait_done_s) begin
                wait_cnt_r <= 16'd0;
            end else begin
                wait_cnt_r <= wait_cnt_r + 16'd1;
            end
        end
    end

`ifdef TD4_HALT_EN
    logic halted_r;

    // Halt flag: set by the committed self-JMP, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            halted_r <= 1'b0;
        end else if (commit_s && halt_hit_s) begin
            halted_r <= 1'b1;
        end
    end

    assign halted = halted_r;
`else
    assign halted = 1'b0;
`endif

    assign pc_out   = pc_r;
    assign reg_a    = reg_a_r;
    assign reg_b    = reg_b_r;
    assign out_port = out_r;
    assign carry    = carry_r;
    assign retire   = retire_r;

endmodule

// File: doc/td4_core.md
# td4_core

TD4 execution core: fetches one 8-bit instruction per instruction period from the program memory at address `pc_out`, decodes it and commits results. Results go to registers A and B, the output latch, the carry flag and the PC. The core sits directly upstream of the program memory, driving its address, and consumes the opcode/immediate nibbles it returns. Instruction rate is throttled by a clock divider so the core can run at demo speed on the shared clock.

## Interface
- `CYCLE_DIV`, default 2: clocks per instruction period; legal range 2..65535.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `run`  in  1  execution enable; 0 freezes the FSM, counter and all architectural state.
- `opcode`  in  4  instruction upper nibble from memory for address `pc_out`.
- `immediate`  in  4  instruction lower nibble from memory for address `pc_out`.
- `in_port`  in  4  external input switches, read by IN instructions.
- `pc_out`  out  4  program counter, the memory address.
- `reg_a`  out  4  register A.
- `reg_b`  out  4  register B.
- `out_port`  out  4  output latch.
- `carry`  out  1  carry flag.
- `retire`  out  1  one-cycle pulse per committed instruction.
- `halted`  out  1  self-loop halt detected; tied 0 without `TD4_HALT_EN`.

## Operation
- ISA, opcode = Im operand:
  - 0000 ADD A,Im
  - 0101 ADD B,Im
  - 0011 MOV A,Im
  - 0111 MOV B,Im
  - 0001 MOV A,B
  - 0100 MOV B,A
  - 0010 IN A
  - 0110 IN B
  - 1001 OUT B
  - 1011 OUT Im
  - 1111 JMP Im
  - 1110 JNC Im
- Any other opcode is a NOP: pc+1, carry cleared, no other effect.
- Arithmetic: 4-bit add, sum wraps mod 16; carry = bit 4 of the 5-bit sum.
- Carry flag is loaded on every commit.
  - ADD: adder carry.
  - All other instructions: 0.
- JNC tests the carry flag as it stood before the JNC, then clears it.
- PC: pc+1 wrapping 15→0, except JMP, and JNC with carry=0, which load Im.
- `out_port` changes only on OUT instructions.
- `in_port` is sampled at the EXEC edge.
- FSM states: FETCH, EXEC, WAIT, plus HALT (macro only).
  - FETCH: latch {opcode, immediate} into IR → EXEC.
  - EXEC: commit IR → WAIT if CYCLE_DIV>2, else → FETCH.
  - WAIT: count CYCLE_DIV-2 cycles → FETCH.
- `run`=0 holds state, counter and all registers. No commit and no `retire` occur while `run` is low. Resumption continues exactly where execution stopped.
- Reset values: pc 0, A 0, B 0, out_port 0, carry 0, retire 0, halted 0, IR 0, counter 0, state FETCH.
- `rst` wins over `run` and over an in-progress EXEC. No partial commit is allowed.

## Timing
- Memory read is combinational from `pc_out`. `opcode`/`immediate` must be valid during the FETCH cycle, and the core samples them at the end of it.
- Instruction period is exactly CYCLE_DIV clocks while `run`=1.
- All architectural outputs update at the EXEC edge.
- `retire` is high for the single cycle following each EXEC edge.
- `pc_out` is stable from the EXEC edge through the next FETCH sample.
- First fetch after reset release is at pc 0, in the first cycle with `rst`=0 and `run`=1.

## Configuration
- `TD4_HALT_EN` defined:
  - A committed JMP whose Im equals its own address enters HALT.
  - `retire` pulses once for that JMP.
  - `halted`=1 thereafter.
  - The FSM stays in HALT until `rst`, ignoring `run`.
- Not defined: the self-JMP re-executes every period, and `halted` is constant 0.

## Structure
- Package `td4_pkg`: opcode localparams, FSM state enum, 4-bit nibble typedef.
- One sub-module, `td4_alu`, combinational:
  - Operand mux: A, B, in_port or 0.
  - Operand + Im adder.
  - Outputs the 4-bit sum and the carry.
- Decode, FSM, divider counter and register file stay in `td4_core`.

## Test plan
- Reset, CYCLE_DIV=2: MOV A,3 at pc0, ADD A,14 at pc1 → A=3, carry=0, then A=1, carry=1. `retire` pulses every 2 clocks.
- Carry=1, then JNC 9 at pc2 → pc=3, carry=0. Second JNC 9 → pc=9.
- in_port=5, IN A → A=5. MOV B,A then OUT B → out_port=5. OUT Im 0xA → out_port=0xA.
- NOP opcode 1000 at pc15 → pc wraps to 0, carry cleared. CYCLE_DIV=5 gives a period of exactly 5 clocks.
- Drop `run` for 7 cycles during EXEC → no state change and no `retire`, then execution resumes. Assert `rst` mid-WAIT → all outputs return to reset values on the next edge.
- JMP 4 at pc4:
  - With `TD4_HALT_EN`: `halted`=1, pc=4, single `retire`, no further pulses.
  - Without: `retire` pulses every period and `halted`=0.
